// File: rtl/resp_tx_queue.sv
// Response byte queue feeding an 8N1 UART transmitter (8E1 when RESP_PARITY_EN is defined).
// Queued bytes go out back-to-back with one idle clock between frames.
module resp_tx_queue #(
    parameter int BAUD_DIV = 2604,
    parameter int DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               resp,
    input  logic                     send_resp,
    input  logic                     clr_ovf,
    output logic                     TX,
    output logic                     resp_sent,
    output logic                     busy,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef RESP_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     mem [DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [7:0]     shift_q, shift_d;
    logic [15:0]    baud_q, baud_d;
    logic [2:0]     bit_q, bit_d;
    logic           tx_d, busy_d, sent_d;
    logic           pop, push, last;
`ifdef RESP_PARITY_EN
    logic           par_q, par_d;
`endif

    assign full = (count == CW'(DEPTH));
    assign last = (baud_q == 16'(BAUD_DIV - 1));
    assign push = send_resp && (!full || pop);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        baud_d  = baud_q + 16'd1;
        bit_d   = bit_q;
        tx_d    = TX;
        busy_d  = busy;
        sent_d  = 1'b0;
        pop     = 1'b0;
`ifdef RESP_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                if (count != '0) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
`ifdef RESP_PARITY_EN
                    par_d   = ^mem[rd_ptr];
`endif
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef RESP_PARITY_EN
                        tx_d    = par_q;
                        state_d = PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        // LSB-first: the next bit is always shift_q[1] before the shift
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
`ifdef RESP_PARITY_EN
            PARITY: begin
                if (last) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (last) begin
                    baud_d  = '0;
                    sent_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            baud_q    <= '0;
            bit_q     <= '0;
            TX        <= 1'b1;
            busy      <= 1'b0;
            resp_sent <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ovf       <= 1'b0;
`ifdef RESP_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            TX        <= tx_d;
            busy      <= busy_d;
            resp_sent <= sent_d;
`ifdef RESP_PARITY_EN
            par_q     <= par_d;
`endif
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // a drop in the same cycle as clr_ovf keeps the flag set
            if (send_resp && !push)
                ovf <= 1'b1;
            else if (clr_ovf)
                ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= resp;
    end

endmodule
